// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for a BCD hundreds/tens/ones value.
// Free-running slot scan with an anode guard band, leading-zero blanking and an "Err" override.
module seven_seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  input  logic       err,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic       err;
  } latch_t;

  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  latch_t        latch_q, latch_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;
  logic          tick;
  logic          h_blank, t_blank;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = 7'h3F; // non-BCD codes show a minus sign
    endcase
  endfunction

  assign tick    = (cnt_q == CW'(CLK_DIV - 1));
  assign h_blank = latch_q.blank_lz && (latch_q.hundreds == 4'd0);
  assign t_blank = h_blank && (latch_q.tens == 4'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    latch_d      = latch_q;
    seg_d        = SEG_BLANK;
    an_d         = 4'hF;
    frame_done_d = tick && (state_q == S3);

    if (tick) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        default: state_d = S0;
      endcase
    end

    if (load) latch_d = '{hundreds, tens, ones, blank_lz, err};

    // Anodes stay dark for the first GUARD cycles of a slot to avoid ghosting.
    if (cnt_q >= CW'(GUARD)) begin
      case (state_q)
        S0: begin
          an_d  = 4'b1110;
          seg_d = latch_q.err ? SEG_R : encode(latch_q.ones);
        end
        S1: begin
          an_d  = 4'b1101;
          seg_d = latch_q.err ? SEG_R : (t_blank ? SEG_BLANK : encode(latch_q.tens));
        end
        S2: begin
          an_d  = 4'b1011;
          seg_d = latch_q.err ? SEG_E : (h_blank ? SEG_BLANK : encode(latch_q.hundreds));
        end
        default: begin
          an_d  = 4'b0111;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: every register here is reset, including the latched digits, so reset shows a defined display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      state_q      <= S0;
      latch_q      <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      latch_q      <= latch_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed scenarios plus random loads,
// compared every cycle against a cycle-count based reference model.
module tb_seven_seg_scan;

  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk, rst_n, load, blank_lz, err;
  logic [3:0] hundreds, tens, ones;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  seven_seg_scan #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .blank_lz   (blank_lz),
    .err        (err),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release plus the latched values.
  int         cyc;
  logic [3:0] m_h, m_t, m_o;
  logic       m_blz, m_err;

  int fd_pulses;
  int fd_last;
  bit fd_track;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0: font = 7'h40;  4'd1: font = 7'h79;  4'd2: font = 7'h24;  4'd3: font = 7'h30;
      4'd4: font = 7'h19;  4'd5: font = 7'h12;  4'd6: font = 7'h02;  4'd7: font = 7'h78;
      4'd8: font = 7'h00;  4'd9: font = 7'h10;
      default: font = 7'h3F;
    endcase
  endfunction

  // Position p (0=ones,1=tens,2=hundreds) blanks when it and every higher digit is zero.
  function automatic logic [6:0] model_seg(input int slot);
    logic [3:0] d [3];
    bit lead_zero;
    d[0] = m_o; d[1] = m_t; d[2] = m_h;
    if (slot == 3) return 7'h7F;
    if (m_err) return (slot == 2) ? 7'h06 : 7'h2F;
    lead_zero = (slot > 0) && m_blz;
    for (int q = slot; q <= 2; q++) if (d[q] != 4'd0) lead_zero = 0;
    return lead_zero ? 7'h7F : font(d[slot]);
  endfunction

  task automatic model_reset();
    cyc = 0; m_h = 0; m_t = 0; m_o = 0; m_blz = 0; m_err = 0;
  endtask

  // One clock: predict from pre-edge model state, advance model, check after the edge.
  task automatic cycle();
    int c, s;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fd;
    c = cyc % CLK_DIV;
    s = (cyc / CLK_DIV) % 4;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    if (c >= GUARD) begin
      exp_an[s] = 1'b0;
      exp_seg   = model_seg(s);
    end
    exp_fd = (c == CLK_DIV - 1) && (s == 3);
    @(posedge clk);
    if (load) begin
      m_h = hundreds; m_t = tens; m_o = ones; m_blz = blank_lz; m_err = err;
    end
    cyc++;
    #1;
    check("seg", seg, exp_seg);
    check("an", an, exp_an);
    check("frame_done", frame_done, exp_fd);
    if (fd_track && frame_done) begin
      if (fd_pulses > 0) check("frame_done_spacing", cyc - fd_last, FRAME);
      fd_pulses++;
      fd_last = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [3:0] h, t, o, input logic blz, e);
    hundreds = h; tens = t; ones = o; blank_lz = blz; err = e; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; hundreds = 0; tens = 0; ones = 0; blank_lz = 0; err = 0;
    fd_track = 0; fd_pulses = 0; fd_last = 0;
    model_reset();
    #12;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic digits 1-2-3.
    do_load(4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    run(2 * FRAME);

    // Leading-zero blanking on and off.
    do_load(4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
    run(FRAME);
    do_load(4'd0, 4'd0, 4'd7, 1'b0, 1'b0);
    run(FRAME);
    do_load(4'd0, 4'd5, 4'd0, 1'b1, 1'b0);
    run(FRAME);

    // Error override, then restore.
    do_load(4'd9, 4'd8, 4'd7, 1'b1, 1'b1);
    run(FRAME);
    do_load(4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
    run(FRAME);

    // Non-BCD code shows minus.
    do_load(4'd3, 4'hC, 4'd1, 1'b0, 1'b0);
    run(FRAME);

    // Load exactly on a tick cycle: next slot already shows new value.
    while (cyc % CLK_DIV != CLK_DIV - 1) cycle();
    do_load(4'd8, 4'd6, 4'd2, 1'b0, 1'b0);
    run(FRAME);

    // Ten frames of frame_done pulses, aligned to a frame boundary.
    while (cyc % FRAME != 0) cycle();
    fd_track = 1; fd_pulses = 0;
    run(10 * FRAME);
    fd_track = 0;
    check("frame_done_count", fd_pulses, 10);

    // Random loads.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0)
        do_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      else
        cycle();
    end

    // Asynchronous reset mid-S2, then restart in S0 with zeroed latches.
    do_load(4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    while (!(((cyc / CLK_DIV) % 4 == 2) && (cyc % CLK_DIV == 4))) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_an", an, 4'hF);
    check("midreset_seg", seg, 7'h7F);
    check("midreset_frame_done", frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter GUARD, default 16, anode-off cycles at the start of each slot; legal range 1..CLK_DIV-2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 load  input  1  one-cycle strobe; latches the digit inputs and the err/blank_lz flags.
REQ-006 hundreds  input  4  BCD hundreds digit from the binary-to-BCD stage.
REQ-007 tens  input  4  BCD tens digit.
REQ-008 ones  input  4  BCD ones digit.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 err  input  1  stack error flag; forces the "Err" display.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 an  output  4  digit anodes, active-low, registered; an[0] is the rightmost digit.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full 4-slot scan.

Function
REQ-014 Latch: on a cycle with load=1, the block SHALL capture hundreds, tens, ones, blank_lz and err into internal registers; with load=0 they hold.
REQ-015 Divider: cnt SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be asserted when cnt==CLK_DIV-1.
REQ-016 Scan FSM: states S0..S3; on tick the FSM SHALL go S0->S1->S2->S3->S0; otherwise it holds.
REQ-017 Slot map: S0 drives ones on an[0], S1 tens on an[1], S2 hundreds on an[2], S3 blank on an[3].
REQ-018 The active anode SHALL be low only while cnt>=GUARD; while cnt<GUARD, an=4'b1111 and seg=7'h7F.
REQ-019 Encoding (seg hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
REQ-020 BCD codes 10..15 SHALL display minus (g only): 7'h3F.
REQ-021 Blanking: with latched blank_lz=1, hundreds==0 is blanked; tens is blanked when hundreds==0 and tens==0; ones is never blanked.
REQ-022 Error: with latched err=1, S2/S1/S0 SHALL show E (7'h06), r (7'h2F), r (7'h2F) and S3 blank, overriding the digit and blanking rules.
REQ-023 Latency: seg/an SHALL be registered and reflect cnt, FSM state and latches of the previous cycle (one-cycle output latency).
REQ-024 A load coinciding with tick SHALL have both take effect; the new slot displays the new latched values.
REQ-025 frame_done SHALL pulse for exactly one cycle, the cycle after the tick taken in S3, aligned with seg/an latency.
REQ-026 load SHALL NOT reset cnt or the FSM; the scan is free-running.

Reset
REQ-027 While rst_n=0: cnt=0, FSM=S0, all latches=0 (err=0, blank_lz=0), an=4'b1111, seg=7'h7F, frame_done=0, asynchronously.
REQ-028 Reset asserted mid-slot SHALL immediately apply REQ-027.
REQ-029 After rst_n rises, the first rising edge SHALL start counting from cnt=0 in S0.

Verification
REQ-030 CLK_DIV=8, GUARD=2; load h=1,t=2,o=3 -> an[0] low with seg=30; then an[1] low with seg=24; then an[2] low with seg=79; an[3] slot seg=7F; each slot 6 active cycles after 2 all-off cycles.
REQ-031 load h=0,t=0,o=7, blank_lz=1 -> only an[0] active, showing 78; S1/S2 slots show 7F; repeat with blank_lz=0 -> 40 shown in S1 and S2.
REQ-032 load err=1 with any digits -> S2=06, S1=2F, S0=2F, S3=7F; a later load with err=0 restores the digits.
REQ-033 load tens=4'hC -> S1 shows 3F; load pulsed exactly on a tick cycle -> the next slot already shows the new value.
REQ-034 Count frame_done pulses over 10 frames -> exactly 10, each 1 cycle wide, spaced 4*CLK_DIV cycles apart.
REQ-035 Assert rst_n=0 mid-S2 -> an=1111, seg=7F, frame_done=0 in the same cycle; after release the scan restarts in S0 with latched digits 0.
